rv32_memory_pipe: RTL and testbench

Parametrised memory stage for the RV32 pipeline, sitting between execute and writeback. It issues loads and stores to a fixed-latency synchronous data memory and formats load data (byte/half/word, signed/unsigned). It carries the instruction's control and data fields through a configurable number of memory stages. It adds stall, flush and valid tracking, so a stalled pipeline never loses in-flight read data and a flushed slot never writes memory or registers.

---
 rtl/rv32_memory_pipe_if.sv | 21 ++
 rtl/rv32_memory_pipe.sv | 178 +++++++++++++++++
 tb/tb_rv32_memory_pipe.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_memory_pipe_if.sv
// Data-memory bus between the RV32 memory stage (master) and a fixed-latency
// synchronous data memory (slave).
interface rv32_memory_pipe_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            mem_en_o;
  logic [3:0]      mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [XLEN-1:0] mem_rdata_i;

  modport master (
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/rv32_memory_pipe.sv
// RV32 memory stage: store lane steering, MEM_LATENCY+1 deep slot pipeline with
// stall/flush/valid tracking, and load formatting. Option: RV32_MEM_MISALIGN_TRAP_EN.
module rv32_memory_pipe #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned XLEN        = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                valid_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                reg_write_i,
  input  logic                fp_reg_write_i,
  input  logic                mem_write_i,
  input  logic                mem_read_i,
  input  logic [2:0]          result_source_i,
  input  logic [XLEN-1:0]     alu_result_i,
  input  logic [XLEN-1:0]     write_data_i,
  input  logic [XLEN-1:0]     instr_i,
  input  logic [XLEN-1:0]     pc_next_i,
  input  logic [XLEN-1:0]     fpu_result_i,
  rv32_memory_pipe_if.master  mem,
  output logic                valid_o,
  output logic                reg_write_o,
  output logic                fp_reg_write_o,
  output logic [2:0]          result_source_o,
  output logic [XLEN-1:0]     alu_result_o,
  output logic [XLEN-1:0]     read_data_o,
  output logic [XLEN-1:0]     instr_o,
  output logic [XLEN-1:0]     pc_next_o,
  output logic [XLEN-1:0]     fpu_result_o,
  output logic                misalign_o
);

  localparam int unsigned LAST = MEM_LATENCY - 1;

  if (XLEN != 32) begin : g_bad_xlen
    $error("rv32_memory_pipe: only XLEN=32 is supported");
  end
  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("rv32_memory_pipe: MEM_LATENCY must be 1..4");
  end

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            fp_reg_write;
    logic            misalign;
    logic [2:0]      result_source;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] fpu_result;
  } slot_t;

  logic            live_c;
  logic [2:0]      f3_c;
  logic [1:0]      off_c;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic            mis_c;
  slot_t           in_c;
  slot_t           last_c;
  slot_t           wb_c;
  logic [XLEN-1:0] shifted_c;
  logic [15:0]     half_c;
  logic [XLEN-1:0] load_c;

  slot_t           stage_q [MEM_LATENCY];
  slot_t           wb_q;
  logic [XLEN-1:0] rdata_q;

  assign live_c = valid_i & ~flush_i;
  assign f3_c   = instr_i[14:12];
  assign off_c  = alu_result_i[1:0];

  // Byte-enable mask and lane replication; offsets are naturally aligned here.
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = write_data_i;
    case (f3_c[1:0])
      2'b00: begin
        be_c    = 4'b0001 << off_c;
        wdata_c = {4{write_data_i[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {off_c[1], 1'b0};
        wdata_c = {2{write_data_i[15:0]}};
      end
      2'b10:   be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

`ifdef RV32_MEM_MISALIGN_TRAP_EN
  assign mis_c = live_c & (mem_read_i | mem_write_i) &
                 ((((f3_c == 3'b001) | (f3_c == 3'b101)) & off_c[0]) |
                  ((f3_c == 3'b010) & (off_c != 2'b00)));
`else
  logic unused_mem_read;
  assign mis_c           = 1'b0;
  assign unused_mem_read = mem_read_i;
`endif

  assign mem.mem_en_o    = rst_n_i & ~stall_i;
  assign mem.mem_addr_o  = alu_result_i;
  assign mem.mem_wdata_o = wdata_c;
  assign mem.mem_we_o    = (rst_n_i & live_c & mem_write_i & ~stall_i & ~mis_c) ? be_c : 4'b0000;

  always_comb begin
    in_c               = '0;
    in_c.valid         = live_c;
    in_c.reg_write     = reg_write_i;
    in_c.fp_reg_write  = fp_reg_write_i;
    in_c.misalign      = mis_c;
    in_c.result_source = result_source_i;
    in_c.alu_result    = alu_result_i;
    in_c.instr         = instr_i;
    in_c.pc_next       = pc_next_i;
    in_c.fpu_result    = fpu_result_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      stage_q[0] <= '0;
    else if (!stall_i) stage_q[0] <= in_c;
  end

  for (genvar k = 1; k < MEM_LATENCY; k++) begin : g_stage
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)      stage_q[k] <= '0;
      else if (!stall_i) stage_q[k] <= stage_q[k-1];
    end
  end

  assign last_c = stage_q[LAST];

  // Load formatting uses funct3/offset of the slot aligned with the read data.
  always_comb begin
    shifted_c = mem.mem_rdata_i >> {last_c.alu_result[1:0], 3'b000};
    half_c    = last_c.alu_result[1] ? mem.mem_rdata_i[31:16] : mem.mem_rdata_i[15:0];
    case (last_c.instr[14:12])
      3'b000:  load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b100:  load_c = {24'h000000, shifted_c[7:0]};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b101:  load_c = {16'h0000, half_c};
      default: load_c = mem.mem_rdata_i;
    endcase
  end

  always_comb begin
    wb_c              = last_c;
    wb_c.reg_write    = last_c.valid & last_c.reg_write & ~last_c.misalign;
    wb_c.fp_reg_write = last_c.valid & last_c.fp_reg_write & ~last_c.misalign;
    wb_c.misalign     = last_c.valid & last_c.misalign;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_q    <= '0;
      rdata_q <= '0;
    end else if (!stall_i) begin
      wb_q    <= wb_c;
      rdata_q <= load_c;
    end
  end

  assign valid_o         = wb_q.valid;
  assign reg_write_o     = wb_q.reg_write;
  assign fp_reg_write_o  = wb_q.fp_reg_write;
  assign result_source_o = wb_q.result_source;
  assign alu_result_o    = wb_q.alu_result;
  assign instr_o         = wb_q.instr;
  assign pc_next_o       = wb_q.pc_next;
  assign fpu_result_o    = wb_q.fpu_result;
  assign read_data_o     = rdata_q;
  assign misalign_o      = wb_q.misalign;

endmodule

// File: tb/tb_rv32_memory_pipe.sv
// Directed bench for rv32_memory_pipe: MEM_LATENCY=1 and MEM_LATENCY=3 instances
// share stimulus, each backed by its own fixed-latency memory model.
module tb_rv32_memory_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid, stall, flush, reg_write, fp_reg_write, mem_write, mem_read;
  logic [2:0]  result_source;
  logic [31:0] alu_result, write_data, instr, pc_next, fpu_result;

  logic        o1_valid, o1_rw, o1_fp, o1_mis;
  logic [2:0]  o1_rs;
  logic [31:0] o1_alu, o1_rd, o1_instr, o1_pcn, o1_fpu;
  logic        o3_valid, o3_rw, o3_fp, o3_mis;
  logic [2:0]  o3_rs;
  logic [31:0] o3_alu, o3_rd, o3_instr, o3_pcn, o3_fpu;

  rv32_memory_pipe_if #(.XLEN(32)) m1 ();
  rv32_memory_pipe_if #(.XLEN(32)) m3 ();

  rv32_memory_pipe #(.MEM_LATENCY(1), .XLEN(32)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .reg_write_i(reg_write), .fp_reg_write_i(fp_reg_write), .mem_write_i(mem_write),
    .mem_read_i(mem_read), .result_source_i(result_source), .alu_result_i(alu_result),
    .write_data_i(write_data), .instr_i(instr), .pc_next_i(pc_next), .fpu_result_i(fpu_result),
    .mem(m1), .valid_o(o1_valid), .reg_write_o(o1_rw), .fp_reg_write_o(o1_fp),
    .result_source_o(o1_rs), .alu_result_o(o1_alu), .read_data_o(o1_rd), .instr_o(o1_instr),
    .pc_next_o(o1_pcn), .fpu_result_o(o1_fpu), .misalign_o(o1_mis)
  );

  rv32_memory_pipe #(.MEM_LATENCY(3), .XLEN(32)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .reg_write_i(reg_write), .fp_reg_write_i(fp_reg_write), .mem_write_i(mem_write),
    .mem_read_i(mem_read), .result_source_i(result_source), .alu_result_i(alu_result),
    .write_data_i(write_data), .instr_i(instr), .pc_next_i(pc_next), .fpu_result_i(fpu_result),
    .mem(m3), .valid_o(o3_valid), .reg_write_o(o3_rw), .fp_reg_write_o(o3_fp),
    .result_source_o(o3_rs), .alu_result_o(o3_alu), .read_data_o(o3_rd), .instr_o(o3_instr),
    .pc_next_o(o3_pcn), .fpu_result_o(o3_fpu), .misalign_o(o3_mis)
  );

  // Memory models: read-before-write, output pipeline advances only when enabled.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] rd1;
  logic [31:0] p3 [3];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 32'h0;
      rd1 <= 32'h0;
    end else if (m1.mem_en_o) begin
      rd1 <= mem1[m1.mem_addr_o[9:2]];
      for (int b = 0; b < 4; b++)
        if (m1.mem_we_o[b]) mem1[m1.mem_addr_o[9:2]][8*b +: 8] <= m1.mem_wdata_o[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem3[i] <= 32'h0;
      for (int j = 0; j < 3; j++) p3[j] <= 32'h0;
    end else if (m3.mem_en_o) begin
      p3[0] <= mem3[m3.mem_addr_o[9:2]];
      p3[1] <= p3[0];
      p3[2] <= p3[1];
      for (int b = 0; b < 4; b++)
        if (m3.mem_we_o[b]) mem3[m3.mem_addr_o[9:2]][8*b +: 8] <= m3.mem_wdata_o[8*b +: 8];
    end
  end

  assign m1.mem_rdata_i = rd1;
  assign m3.mem_rdata_i = p3[2];

  typedef struct {
    logic        wr, rd, rw, fp;
    logic [2:0]  f3;
    logic [31:0] addr, wd;
    logic        flush;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
    logic        exp_valid, exp_rw, exp_fp, exp_mis, chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

`ifdef RV32_MEM_MISALIGN_TRAP_EN
  localparam logic [31:0] W100 = 32'h80FF7F01;
`else
  localparam logic [31:0] W100 = 32'h80FF1234;
`endif

  int tests = 0;
  int fails = 0;
  vec_t vt [19];

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic wr, rd, rw, fp, input logic [2:0] f3,
                               input logic [31:0] addr, wd, input logic fl,
                               input logic [3:0] we, input logic [31:0] wdata,
                               input logic ev, erw, efp, emis, crd, input logic [31:0] erd);
    vec_t v;
    v.wr = wr; v.rd = rd; v.rw = rw; v.fp = fp; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.flush = fl; v.exp_we = we; v.exp_wdata = wdata; v.exp_valid = ev; v.exp_rw = erw;
    v.exp_fp = efp; v.exp_mis = emis; v.chk_rd = crd; v.exp_rd = erd;
    return v;
  endfunction

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [31:0] a, input logic wr);
    return {a[11:0], 5'd1, f3, 5'd2, (wr ? 7'h23 : 7'h03)};
  endfunction

  task automatic drive(input logic v, wr, rd, rw, fp, input logic [2:0] f3,
                       input logic [31:0] a, d, input logic fl, st);
    valid = v; mem_write = wr; mem_read = rd; reg_write = rw; fp_reg_write = fp;
    instr = mk_instr(f3, a, wr); result_source = f3 ^ 3'b101;
    alu_result = a; write_data = d; pc_next = a + 32'd4; fpu_result = ~a;
    flush = fl; stall = st;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h3FC, 32'h0, 1'b0, 1'b0);
  endtask

  // One transaction alone in the L=1 pipe: check the bus now, writeback 2 edges later.
  task automatic apply_vec(input string nm, input vec_t v);
    drive(1'b1, v.wr, v.rd, v.rw, v.fp, v.f3, v.addr, v.wd, v.flush, 1'b0);
    #1;
    chk({nm, "_we"}, 160'(m1.mem_we_o), 160'(v.exp_we));
    chk({nm, "_wdata"}, 160'(m1.mem_wdata_o), 160'(v.exp_wdata));
    chk({nm, "_addr"}, 160'(m1.mem_addr_o), 160'(v.addr));
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    chk({nm, "_valid"}, 160'(o1_valid), 160'(v.exp_valid));
    chk({nm, "_rw"}, 160'(o1_rw), 160'(v.exp_rw));
    chk({nm, "_fp"}, 160'(o1_fp), 160'(v.exp_fp));
    chk({nm, "_mis"}, 160'(o1_mis), 160'(v.exp_mis));
    if (v.chk_rd) chk({nm, "_rdata"}, 160'(o1_rd), 160'(v.exp_rd));
    if (v.exp_valid)
      chk({nm, "_pass"}, 160'({o1_rs, o1_alu, o1_instr, o1_pcn, o1_fpu}),
          160'({v.f3 ^ 3'b101, v.addr, mk_instr(v.f3, v.addr, v.wr), v.addr + 32'd4, ~v.addr}));
  endtask

  initial begin
    //            wr rd rw fp f3      addr         wd            fl we       wdata         v  rw fp ms ck rd
    vt[0]  = mkv(1, 0, 0, 0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF, 1, 0, 0, 0, 0, 32'h0);
    vt[1]  = mkv(0, 1, 1, 0, 3'b010, 32'h100, 32'h0,        0, 4'b0000, 32'h0,        1, 1, 0, 0, 1, 32'hDEADBEEF);
    vt[2]  = mkv(1, 0, 0, 0, 3'b010, 32'h100, 32'h80FF7F01, 0, 4'b1111, 32'h80FF7F01, 1, 0, 0, 0, 0, 32'h0);
    vt[3]  = mkv(0, 1, 1, 0, 3'b000, 32'h103, 32'h0,        0, 4'b0000, 32'h0,        1, 1, 0, 0, 1, 32'hFFFFFF80);
    vt[4]  = mkv(0, 1, 1, 0, 3'b100, 32'h103, 32'h0,        0, 4'b0000, 32'h0,        1, 1, 0, 0, 1, 32'h00000080);
    vt[5]  = mkv(0, 1, 1, 0, 3'b001, 32'h102, 32'h0,        0, 4'b0000, 32'h0,        1, 1, 0, 0, 1, 32'hFFFF80FF);
    vt[6]  = mkv(0, 1, 1, 0, 3'b101, 32'h102, 32'h0,        0, 4'b0000, 32'h0,        1, 1, 0, 0, 1, 32'h000080FF);
    vt[7]  = mkv(0, 1, 1, 0, 3'b000, 32'h100, 32'h0,        0, 4'b0000, 32'h0,        1, 1, 0, 0, 1, 32'h00000001);
    vt[8]  = mkv(0, 1, 1, 0, 3'b001, 32'h100, 32'h0,        0, 4'b0000, 32'h0,        1, 1, 0, 0, 1, 32'h00007F01);
    vt[9]  = mkv(1, 0, 0, 0, 3'b000, 32'h201, 32'h123456A5, 0, 4'b0010, 32'hA5A5A5A5, 1, 0, 0, 0, 0, 32'h0);
    vt[10] = mkv(1, 0, 0, 0, 3'b001, 32'h202, 32'hFFFFBEEF, 0, 4'b1100, 32'hBEEFBEEF, 1, 0, 0, 0, 0, 32'h0);
    vt[11] = mkv(0, 1, 1, 0, 3'b010, 32'h200, 32'h0,        0, 4'b0000, 32'h0,        1, 1, 0, 0, 1, 32'hBEEFA500);
    vt[12] = mkv(0, 1, 1, 0, 3'b100, 32'h201, 32'h0,        0, 4'b0000, 32'h0,        1, 1, 0, 0, 1, 32'h000000A5);
    vt[13] = mkv(1, 0, 0, 0, 3'b010, 32'h200, 32'h11111111, 1, 4'b0000, 32'h11111111, 0, 0, 0, 0, 0, 32'h0);
    vt[14] = mkv(0, 1, 0, 1, 3'b010, 32'h200, 32'h0,        0, 4'b0000, 32'h0,        1, 0, 1, 0, 1, 32'hBEEFA500);
`ifdef RV32_MEM_MISALIGN_TRAP_EN
    vt[15] = mkv(0, 1, 1, 0, 3'b010, 32'h102, 32'h0,        0, 4'b0000, 32'h0,        1, 0, 0, 1, 0, 32'h0);
    vt[16] = mkv(1, 0, 0, 0, 3'b001, 32'h101, 32'h00001234, 0, 4'b0000, 32'h12341234, 1, 0, 0, 1, 0, 32'h0);
`else
    vt[15] = mkv(0, 1, 1, 0, 3'b010, 32'h102, 32'h0,        0, 4'b0000, 32'h0,        1, 1, 0, 0, 1, 32'h80FF7F01);
    vt[16] = mkv(1, 0, 0, 0, 3'b001, 32'h101, 32'h00001234, 0, 4'b0011, 32'h12341234, 1, 0, 0, 0, 0, 32'h0);
`endif
    vt[17] = mkv(0, 1, 1, 0, 3'b010, 32'h100, 32'h0,        0, 4'b0000, 32'h0,        1, 1, 0, 0, 1, W100);
    vt[18] = mkv(0, 0, 0, 1, 3'b000, 32'h055, 32'h0,        0, 4'b0000, 32'h0,        1, 0, 1, 0, 0, 32'h0);

    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid1", 160'(o1_valid), 160'(1'b0));
    chk("rst_rw1", 160'(o1_rw), 160'(1'b0));
    chk("rst_rdata1", 160'(o1_rd), 160'(32'h0));
    chk("rst_en1", 160'(m1.mem_en_o), 160'(1'b0));
    chk("rst_we1", 160'(m1.mem_we_o), 160'(4'b0000));
    chk("rst_valid3", 160'(o3_valid), 160'(1'b0));
    chk("rst_mis1", 160'(o1_mis), 160'(1'b0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("en_after_rst", 160'(m1.mem_en_o), 160'(1'b1));

    for (int i = 0; i < 19; i++) apply_vec($sformatf("v%0d", i), vt[i]);

    // Back-to-back store then load, one instruction per cycle.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h300, 32'hCAFEF00D, 1'b0, 1'b0);
    #1 chk("b2b_sw_we", 160'(m1.mem_we_o), 160'(4'b1111));
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b0, 1'b0);
    #1 chk("b2b_lw_we", 160'(m1.mem_we_o), 160'(4'b0000));
    @(posedge clk); #1;
    chk("b2b_sw_valid", 160'({o1_valid, o1_rw}), 160'(2'b10));
    idle();
    @(posedge clk); #1;
    chk("b2b_lw_out", 160'({o1_valid, o1_rw, o1_rd}), 160'({2'b11, 32'hCAFEF00D}));
    @(posedge clk); #1;
    chk("b2b_bubble", 160'(o1_valid), 160'(1'b0));

    // Stall with a load in flight in both pipes; live store (then store+flush) at input.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    chk("st_pre1", 160'({o1_valid, o1_rw, o1_rd}), 160'({2'b11, W100}));
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 1'b1);
    #1;
    chk("st_en1", 160'(m1.mem_en_o), 160'(1'b0));
    chk("st_en3", 160'(m3.mem_en_o), 160'(1'b0));
    chk("st_we", 160'(m1.mem_we_o), 160'(4'b0000));
    for (int c = 0; c < 5; c++) begin
      if (c >= 2) flush = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("st_hold1_%0d", c), 160'({o1_valid, o1_rw, o1_rd}), 160'({2'b11, W100}));
      chk($sformatf("st_hold3_%0d", c), 160'(o3_valid), 160'(1'b0));
      chk($sformatf("st_we_%0d", c), 160'(m3.mem_we_o), 160'(4'b0000));
    end
    idle();
    @(posedge clk); #1;
    chk("lat3_e3", 160'(o3_valid), 160'(1'b0));
    chk("lat3_e3_dut1", 160'(o1_valid), 160'(1'b0));
    @(posedge clk); #1;
    chk("lat3_e4", 160'({o3_valid, o3_rw, o3_rd}), 160'({2'b11, W100}));
    apply_vec("post_stall", mkv(0, 1, 1, 0, 3'b010, 32'h100, 32'h0, 0, 4'b0000, 32'h0, 1, 1, 0, 0, 1, W100));

    // Asynchronous reset in the middle of a valid writeback.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    idle();
    @(posedge clk); #2;
    chk("arst_pre", 160'(o1_valid), 160'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("arst_valid1", 160'({o1_valid, o1_rw}), 160'(2'b00));
    chk("arst_en1", 160'(m1.mem_en_o), 160'(1'b0));
    chk("arst_valid3", 160'(o3_valid), 160'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
